// File: rtl/cordic_mag_window.sv
// Window reducer for the cordic magnitude stream: every 2^LOG2_N valid samples produce one
// registered mean/max/min result with a sticky overflow flag for results lost to back-pressure.
module cordic_mag_window #(
  parameter int unsigned Q_I    = 15,
  parameter int unsigned Q_F    = 16,
  parameter int unsigned LOG2_N = 4,
  localparam int unsigned WIDTH = Q_I + Q_F + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] mean_o,
  output logic [WIDTH-1:0] max_o,
  output logic [WIDTH-1:0] min_o,
  output logic             overflow_o
);

  localparam int unsigned AccW = WIDTH + LOG2_N;
  localparam logic [WIDTH-1:0] MinInit = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e              state_q, state_d;
  logic [LOG2_N-1:0]   cnt_q, cnt_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]    run_max_q, run_max_d;
  logic [WIDTH-1:0]    run_min_q, run_min_d;
  logic [WIDTH-1:0]    mean_q, mean_d;
  logic [WIDTH-1:0]    max_q, max_d;
  logic [WIDTH-1:0]    min_q, min_d;
  logic                ovf_q, ovf_d;

  logic [WIDTH-1:0]    sample;
  logic [AccW-1:0]     acc_sum;
  logic [WIDTH-1:0]    max_new;
  logic [WIDTH-1:0]    min_new;
  logic                accept;
  logic                complete;
  logic                load;

  // Negative magnitudes can only be cordic artefacts; treat them as zero.
  assign sample   = data_i[WIDTH-1] ? '0 : data_i;
  assign acc_sum  = acc_q + AccW'(sample);
  assign max_new  = (sample > run_max_q) ? sample : run_max_q;
  assign min_new  = (sample < run_min_q) ? sample : run_min_q;
  assign accept   = valid_i && !clear_i;
  assign complete = accept && (&cnt_q);

  // Window accumulation
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    if (clear_i || complete) begin
      cnt_d     = '0;
      acc_d     = '0;
      run_max_d = '0;
      run_min_d = MinInit;
    end else if (accept) begin
      cnt_d     = cnt_q + LOG2_N'(1);
      acc_d     = acc_sum;
      run_max_d = max_new;
      run_min_d = min_new;
    end
  end

  // Output handshake FSM
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    if (clear_i) begin
      state_d = StEmpty;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (complete) begin
            state_d = StFull;
            load    = 1'b1;
          end
        end
        StFull: begin
          if (complete) begin
            load = 1'b1;
            if (!ready_i) ovf_d = 1'b1;
          end else if (ready_i) begin
            state_d = StEmpty;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    mean_d = mean_q;
    max_d  = max_q;
    min_d  = min_q;
    if (load) begin
      mean_d = acc_sum[LOG2_N +: WIDTH];
      max_d  = max_new;
      min_d  = min_new;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StEmpty;
      cnt_q     <= '0;
      acc_q     <= '0;
      run_max_q <= '0;
      run_min_q <= MinInit;
      mean_q    <= '0;
      max_q     <= '0;
      min_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      mean_q    <= mean_d;
      max_q     <= max_d;
      min_q     <= min_d;
      ovf_q     <= ovf_d;
    end
  end

  assign valid_o    = (state_q == StFull);
  assign mean_o     = mean_q;
  assign max_o      = max_q;
  assign min_o      = min_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_cordic_mag_window.sv
// Bench for cordic_mag_window: window table, directed handshake/clear/reset sequences and
// randomized traffic against a queue-based window model.
module tb_cordic_mag_window;

  localparam int unsigned QI = 15;
  localparam int unsigned QF = 16;
  localparam int unsigned L2N = 4;
  localparam int unsigned W = QI + QF + 1;
  localparam int unsigned N = 1 << L2N;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         clear_i = 1'b0;
  logic         valid_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         ready_i = 1'b0;
  logic         valid_o;
  logic [W-1:0] mean_o;
  logic [W-1:0] max_o;
  logic [W-1:0] min_o;
  logic         overflow_o;

  cordic_mag_window #(.Q_I(QI), .Q_F(QF), .LOG2_N(L2N)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .mean_o     (mean_o),
    .max_o      (max_o),
    .min_o      (min_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of conditioned samples of the open window plus the result register.
  longint unsigned win_q[$];
  bit              exp_valid;
  bit              exp_ovf;
  logic [W-1:0]    exp_mean, exp_max, exp_min;

  typedef struct {
    logic [W-1:0] base;
    logic [W-1:0] step;
    bit           neg_last;
    logic [W-1:0] mean;
    logic [W-1:0] max;
    logic [W-1:0] min;
  } win_vec_t;

  win_vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    win_q.delete();
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_mean  = '0;
    exp_max   = '0;
    exp_min   = '0;
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic r, input logic c);
    longint unsigned s, sum, mx, mn;
    bit done;
    if (c) begin
      win_q.delete();
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      done = 1'b0;
      if (v) begin
        s = d[W-1] ? 0 : longint'(d);
        win_q.push_back(s);
        if (win_q.size() == N) begin
          sum = 0;
          mx  = 0;
          mn  = win_q[0];
          foreach (win_q[i]) begin
            sum += win_q[i];
            if (win_q[i] > mx) mx = win_q[i];
            if (win_q[i] < mn) mn = win_q[i];
          end
          win_q.delete();
          done = 1'b1;
          if (exp_valid && !r) exp_ovf = 1'b1;
          exp_valid = 1'b1;
          exp_mean  = W'(sum / N);
          exp_max   = W'(mx);
          exp_min   = W'(mn);
        end
      end
      if (!done && exp_valid && r) exp_valid = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, 64'(valid_o), 64'(exp_valid));
    chk({tag, ".ovf"}, 64'(overflow_o), 64'(exp_ovf));
    chk({tag, ".mean"}, 64'(mean_o), 64'(exp_mean));
    chk({tag, ".max"}, 64'(max_o), 64'(exp_max));
    chk({tag, ".min"}, 64'(min_o), 64'(exp_min));
  endtask

  // Drive one cycle, advance the model on the same edge, compare 1 time unit later.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic c,
                      input string tag);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    clear_i = c;
    @(posedge clk_i);
    model_edge(v, d, r, c);
    #1;
    compare_all(tag);
  endtask

  logic [W-1:0] smp;

  initial begin
    vecs[0] = '{base: 32'h0001_0000, step: 32'h0001_0000, neg_last: 1'b0,
                mean: 32'h0008_8000, max: 32'h0010_0000, min: 32'h0001_0000};
    vecs[1] = '{base: 32'h0003_0000, step: 32'h0, neg_last: 1'b1,
                mean: 32'h0002_D000, max: 32'h0003_0000, min: 32'h0};
    vecs[2] = '{base: 32'h0002_0000, step: 32'h0, neg_last: 1'b0,
                mean: 32'h0002_0000, max: 32'h0002_0000, min: 32'h0002_0000};
    vecs[3] = '{base: 32'h7FFF_FFFF, step: 32'h0, neg_last: 1'b0,
                mean: 32'h7FFF_FFFF, max: 32'h7FFF_FFFF, min: 32'h7FFF_FFFF};
    vecs[4] = '{base: 32'h0, step: 32'h1, neg_last: 1'b0,
                mean: 32'h7, max: 32'hF, min: 32'h0};
    vecs[5] = '{base: 32'h0, step: 32'h0, neg_last: 1'b0,
                mean: 32'h0, max: 32'h0, min: 32'h0};

    model_reset();
    #12;
    compare_all("reset");
    rst_ni = 1'b1;
    #10;

    // Table of full windows, always ready
    foreach (vecs[k]) begin
      for (int i = 0; i < N; i++) begin
        smp = vecs[k].base + W'(i) * vecs[k].step;
        if (vecs[k].neg_last && i == N - 1) smp = 32'hFFFF_0000;
        step(1'b1, smp, 1'b1, 1'b0, "tbl");
      end
      chk("tbl.valid", 64'(valid_o), 64'd1);
      chk("tbl.mean", 64'(mean_o), 64'(vecs[k].mean));
      chk("tbl.max", 64'(max_o), 64'(vecs[k].max));
      chk("tbl.min", 64'(min_o), 64'(vecs[k].min));
    end
    step(1'b0, '0, 1'b1, 1'b0, "drain");
    chk("single_cycle_valid", 64'(valid_o), 64'd0);

    // Pending result, ready raised exactly in the next completion cycle
    for (int i = 1; i <= 2 * N; i++)
      step(1'b1, W'(i) << 16, (i == 2 * N), 1'b0, "rdy_edge");
    chk("rdy_edge.valid", 64'(valid_o), 64'd1);
    chk("rdy_edge.ovf", 64'(overflow_o), 64'd0);
    chk("rdy_edge.mean", 64'(mean_o), 64'h0018_8000);
    step(1'b0, '0, 1'b1, 1'b0, "drain");

    // Two windows with no ready: second overwrites first
    for (int i = 1; i <= 2 * N; i++) begin
      step(1'b1, W'(i) << 16, 1'b0, 1'b0, "ovf");
      if (i == N) chk("ovf.valid16", 64'(valid_o), 64'd1);
      if (i == N) chk("ovf.noovf16", 64'(overflow_o), 64'd0);
    end
    chk("ovf.flag", 64'(overflow_o), 64'd1);
    chk("ovf.mean", 64'(mean_o), 64'h0018_8000);
    chk("ovf.max", 64'(max_o), 64'h0020_0000);
    chk("ovf.min", 64'(min_o), 64'h0011_0000);
    step(1'b0, '0, 1'b1, 1'b0, "ovf_sticky");
    chk("ovf.sticky", 64'(overflow_o), 64'd1);

    // Clear mid-window drops the partial window and the same-cycle sample
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0007_0000, 1'b1, 1'b0, "clr");
    step(1'b1, 32'h0007_0000, 1'b1, 1'b1, "clr");
    chk("clr.ovf", 64'(overflow_o), 64'd0);
    for (int i = 0; i < N; i++) step(1'b1, 32'h0002_0000, 1'b1, 1'b0, "clr");
    chk("clr.valid", 64'(valid_o), 64'd1);
    chk("clr.mean", 64'(mean_o), 64'h0002_0000);
    chk("clr.min", 64'(min_o), 64'h0002_0000);

    // Asynchronous reset in the middle of a clock period
    for (int i = 0; i < 10; i++) step(1'b1, 32'h0009_0000, 1'b1, 1'b0, "arst");
    #2 rst_ni = 1'b0;
    model_reset();
    #1;
    compare_all("arst.async");
    valid_i = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < N; i++) step(1'b1, 32'h0004_0000, 1'b1, 1'b0, "arst");
    chk("arst.valid", 64'(valid_o), 64'd1);
    chk("arst.mean", 64'(mean_o), 64'h0004_0000);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      smp = W'($urandom);
      if ($urandom_range(0, 3) != 0) smp[W-1] = 1'b0;
      step(($urandom_range(0, 9) < 7), smp, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 79) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_mag_window.md
Name: cordic_mag_window

Overview:
- Downstream stage of the cordic magnitude unit.
- Consumes its valid-only Q_I.Q_F magnitude stream and reduces each window of 2^LOG2_N samples to mean, maximum and minimum.
- Presents each window result on a valid/ready output register with a sticky overflow flag, because the cordic side cannot be back-pressured.

Parameters:
- Q_I, 15, integer bits of the fixed-point format.
- Q_F, 16, fractional bits of the fixed-point format.
- LOG2_N, 4, log2 of window length N (N = 16 by default; LOG2_N >= 1).
- Derived WIDTH = Q_I + Q_F + 1 (sign bit included, matches cordic data_o).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous flush of partial window, output register and overflow flag.
- valid_i  in  1  data_i carries a cordic magnitude this cycle.
- data_i  in  WIDTH  signed Q_I.Q_F magnitude sample.
- ready_i  in  1  downstream accepts the current result.
- valid_o  out  1  result registers hold an unconsumed window result.
- mean_o  out  WIDTH  window mean, Q_I.Q_F.
- max_o  out  WIDTH  window maximum, Q_I.Q_F.
- min_o  out  WIDTH  window minimum, Q_I.Q_F.
- overflow_o  out  1  sticky: a result was overwritten before being accepted.

Behaviour:
- Reset (rst_ni low, asynchronous): valid_o, mean_o, max_o, min_o, overflow_o = 0; sample counter = 0; accumulator = 0; running max = 0; running min = all-ones positive (0111...1).
- Sample conditioning: if data_i[WIDTH-1] = 1, the sample is clamped to 0 before any arithmetic. Otherwise it is used as-is (unsigned, WIDTH-1 magnitude bits).
- Accumulator:
  - Width WIDTH + LOG2_N; cannot overflow.
  - Counter is LOG2_N bits and wraps N-1 -> 0.
- Each cycle with valid_i = 1 and clear_i = 0: acc += s, run_max = max(run_max, s), run_min = min(run_min, s), cnt++.
- Window completion: the cycle in which valid_i = 1 and cnt = N-1.
  - Result uses the current sample: mean = (acc + s) >> LOG2_N, truncating; max and min include s.
  - Result is loaded into the output registers at that clock edge, so valid_o = 1 on the following cycle (latency 1).
  - acc, run_max, run_min and cnt reinitialise on the same edge. Back-to-back windows need no bubble.
- Output FSM has two states, EMPTY and FULL (valid_o = state == FULL).
  - EMPTY + completion -> FULL.
  - FULL + ready_i = 1 + no completion -> EMPTY.
  - FULL + ready_i = 1 + completion -> FULL with new result loaded; no overflow.
  - FULL + ready_i = 0 + completion -> FULL, new result overwrites the old one, overflow_o set to 1.
  - Output registers hold stable while FULL and ready_i = 0 with no completion.
- overflow_o remains 1 until clear_i or reset.
- clear_i = 1 has priority over everything:
  - The same-cycle sample is dropped.
  - Accumulators and counter reinitialise; the FSM goes to EMPTY; overflow_o = 0.
  - mean_o, max_o and min_o keep their last values but are invalid.
- ready_i is ignored while EMPTY.
- No combinational path from any input to any output.

Test Plan:
- Q15.16, LOG2_N = 4, ready_i = 1; 16 consecutive samples 1.0..16.0 (0x00010000..0x00100000) -> valid_o high exactly 1 cycle after the 16th sample for 1 cycle; mean_o = 0x00088000 (8.5), max_o = 0x00100000, min_o = 0x00010000.
- ready_i = 0; 32 consecutive samples 1.0..32.0 -> valid_o stays high from cycle after sample 16; overflow_o = 1 one cycle after sample 32; mean_o = 0x00188000 (24.5), max_o = 0x00200000, min_o = 0x00110000.
- Result pending with ready_i = 0, then ready_i = 1 in exactly the completion cycle of the next window -> valid_o stays 1, new result loaded, overflow_o remains 0.
- 5 samples of 7.0, clear_i one cycle (with valid_i = 1), then 16 samples of 2.0 -> single result with mean_o = max_o = min_o = 0x00020000; overflow_o = 0.
- Window of 15 samples of 3.0 plus one sample 0xFFFF0000 (negative) -> min_o = 0, max_o = 0x00030000, mean_o = 0x0002D000 (2.8125).
- Assert rst_ni low asynchronously mid-clock after 10 samples -> all outputs 0 immediately, before the next edge; after release, 16 samples of 4.0 -> one result, mean_o = 0x00040000.
